// File: rtl/corr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : corr_pkg
// Purpose : Correlator register map, geometry and sequencer state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package corr_pkg;

   localparam logic [7:0] CORR_TMPL_BASE = 8'h00;
   localparam logic [7:0] CORR_SIG_BASE  = 8'h04;
   localparam logic [7:0] CORR_SYNC      = 8'h0A;
   localparam logic [7:0] CORR_ACK       = 8'h0B;
   localparam logic [7:0] CORR_RES_BASE  = 8'h10;

   localparam int CORR_TAPS       = 16;
   localparam int CORR_LAGS       = 5;
   localparam int CORR_TMPL_WORDS = CORR_TAPS / 4;
   // 16 taps slid over 5 lags need 20 signal bytes
   localparam int CORR_SIG_WORDS  = (CORR_TAPS + CORR_LAGS - 1 + 3) / 4;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_CLR     = 4'd1,
      ST_TMPL    = 4'd2,
      ST_FILL    = 4'd3,
      ST_WR_SIG  = 4'd4,
      ST_SYNC_HI = 4'd5,
      ST_POLL_HI = 4'd6,
      ST_RD      = 4'd7,
      ST_OUT     = 4'd8,
      ST_SYNC_LO = 4'd9,
      ST_POLL_LO = 4'd10,
      ST_NEXT    = 4'd11,
      ST_ABORT   = 4'd12,
      ST_DONE    = 4'd13
   } corr_state_t;

   function automatic logic [7:0] corr_addr(input logic [7:0] base, input logic [2:0] idx);
      return base + {5'b0, idx};
   endfunction

endpackage
`default_nettype wire

// File: rtl/corr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : corr_sequencer_if
// Purpose : Avalon-MM single-cycle bus between the sequencer and correlator.
// Revision: 1.0 - initial release
// ============================================================================
interface corr_sequencer_if;
   logic [7:0]  avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata;

   modport master (
      output avm_address, avm_read, avm_write, avm_writedata,
      input  avm_readdata
   );

   modport slave (
      input  avm_address, avm_read, avm_write, avm_writedata,
      output avm_readdata
   );
endinterface
`default_nettype wire

// File: rtl/corr_sequencer_sig_window.sv
`default_nettype none
// ============================================================================
// Module  : corr_sig_window
// Purpose : Five-word signal buffer: sequential fill, slide-by-one, read port.
// Revision: 1.0 - initial release
// ============================================================================
module corr_sig_window
   import corr_pkg::*;
#(
   parameter int DEPTH = CORR_SIG_WORDS
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_clear,
   input  logic        i_load,
   input  logic        i_shift,
   input  logic [31:0] i_din,
   input  logic [2:0]  i_rd_idx,
   output logic [31:0] o_rd_word,
   output logic [2:0]  o_count
);
   logic [31:0] r_sbuf [DEPTH];
   logic [2:0]  r_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= 3'd0;
         for (int i = 0; i < DEPTH; i++) r_sbuf[i] <= '0;
      end else if (i_clear) begin
         r_count <= 3'd0;
      end else if (i_load && (r_count < 3'(DEPTH))) begin
         r_sbuf[r_count] <= i_din;
         r_count         <= r_count + 3'd1;
      end else if (i_shift) begin
         // oldest word drops out of slot 0, newest enters the top slot
         for (int i = 0; i < DEPTH - 1; i++) r_sbuf[i] <= r_sbuf[i+1];
         r_sbuf[DEPTH-1] <= i_din;
      end
   end

   assign o_rd_word = (i_rd_idx < 3'(DEPTH)) ? r_sbuf[i_rd_idx] : '0;
   assign o_count   = r_count;
endmodule
`default_nettype wire

// File: rtl/corr_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : corr_sequencer
// Purpose : Bus master that feeds template and sliding windows to the
//           correlator and streams out the five lag results per window.
// Revision: 1.0 - initial release
// ============================================================================
module corr_sequencer
   import corr_pkg::*;
#(
   parameter int N_WIN_W     = 16,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [N_WIN_W-1:0] num_windows,
   output logic               busy,
   output logic               done,
   output logic               err,
   input  logic [31:0]        in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [31:0]        res_data,
   output logic [N_WIN_W+2:0] res_lag,
   output logic               res_valid,
   input  logic               res_ready,
   corr_sequencer_if.master   avm
);
   localparam int                  c_POLL_W    = $clog2(ACK_TIMEOUT + 1);
   localparam logic [c_POLL_W-1:0] c_POLL_LAST = c_POLL_W'(ACK_TIMEOUT - 1);

   corr_state_t          r_state, w_state_d;
   logic [2:0]           r_cnt, w_cnt_d;
   logic [c_POLL_W-1:0]  r_poll, w_poll_d;
   logic [N_WIN_W-1:0]   r_win, w_win_d, r_nwin, w_nwin_d;
   logic                 r_busy, w_busy_d, r_done, w_done_d, r_err, w_err_d;
   logic                 r_in_ready, w_in_ready_d, r_res_valid, w_res_valid_d;
   logic [31:0]          r_res_data, w_res_data_d;
   logic [N_WIN_W+2:0]   r_res_lag, w_res_lag_d;
   logic [7:0]           r_addr, w_addr_d;
   logic                 r_rd, w_rd_d, r_wr, w_wr_d;
   logic [31:0]          r_wdata, w_wdata_d;
   logic                 w_win_clear, w_win_load, w_win_shift;
   logic [2:0]           w_rd_idx, w_win_count;
   logic [31:0]          w_rd_word;
   logic                 w_last, w_ack_ok;

   corr_sig_window u_sig_window (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_clear   (w_win_clear),
      .i_load    (w_win_load),
      .i_shift   (w_win_shift),
      .i_din     (in_data),
      .i_rd_idx  (w_rd_idx),
      .o_rd_word (w_rd_word),
      .o_count   (w_win_count)
   );

   assign w_last   = (r_win == r_nwin - 1'b1);
   assign w_ack_ok = (r_state == ST_POLL_HI) ? avm.avm_readdata[0] : !avm.avm_readdata[0];

   always_comb begin
      w_state_d     = r_state;
      w_cnt_d       = r_cnt;
      w_poll_d      = r_poll;
      w_win_d       = r_win;
      w_nwin_d      = r_nwin;
      w_done_d      = 1'b0;
      w_err_d       = r_err;
      w_in_ready_d  = r_in_ready;
      w_res_data_d  = r_res_data;
      w_res_lag_d   = r_res_lag;
      w_res_valid_d = r_res_valid;
      w_addr_d      = r_addr;
      w_rd_d        = 1'b0;
      w_wr_d        = 1'b0;
      w_wdata_d     = r_wdata;
      w_win_clear   = 1'b0;
      w_win_load    = 1'b0;
      w_win_shift   = 1'b0;
      w_rd_idx      = 3'd0;

      // Outputs are registered, so each branch sets what the next state shows.
      case (r_state)
         ST_IDLE: if (start) begin
            w_state_d   = ST_CLR;
            w_nwin_d    = num_windows;
            w_err_d     = 1'b0;
            w_win_d     = '0;
            w_cnt_d     = 3'd0;
            w_win_clear = 1'b1;
            w_wr_d      = 1'b1;
            w_addr_d    = CORR_SYNC;
            w_wdata_d   = 32'd0;
         end
         ST_CLR: if (r_nwin == '0) begin
            w_state_d = ST_DONE;
            w_done_d  = 1'b1;
         end else begin
            w_state_d    = ST_TMPL;
            w_in_ready_d = 1'b1;
         end
         ST_TMPL: if (in_valid) begin
            w_wr_d    = 1'b1;
            w_addr_d  = corr_addr(CORR_TMPL_BASE, r_cnt);
            w_wdata_d = in_data;
            if (r_cnt == 3'(CORR_TMPL_WORDS - 1)) begin
               w_state_d = ST_FILL;
               w_cnt_d   = 3'd0;
            end else begin
               w_cnt_d = r_cnt + 3'd1;
            end
         end
         ST_FILL: if (in_valid) begin
            w_win_load = 1'b1;
            if (w_win_count == 3'(CORR_SIG_WORDS - 1)) begin
               w_state_d    = ST_WR_SIG;
               w_in_ready_d = 1'b0;
               w_cnt_d      = 3'd0;
               w_wr_d       = 1'b1;
               w_addr_d     = CORR_SIG_BASE;
               w_wdata_d    = w_rd_word;
            end
         end
         ST_WR_SIG: if (r_cnt == 3'(CORR_SIG_WORDS - 1)) begin
            w_state_d = ST_SYNC_HI;
            w_wr_d    = 1'b1;
            w_addr_d  = CORR_SYNC;
            w_wdata_d = 32'd1;
         end else begin
            w_cnt_d   = r_cnt + 3'd1;
            w_rd_idx  = r_cnt + 3'd1;
            w_wr_d    = 1'b1;
            w_addr_d  = corr_addr(CORR_SIG_BASE, r_cnt + 3'd1);
            w_wdata_d = w_rd_word;
         end
         ST_SYNC_HI, ST_SYNC_LO: begin
            w_state_d = (r_state == ST_SYNC_HI) ? ST_POLL_HI : ST_POLL_LO;
            w_poll_d  = '0;
            w_rd_d    = 1'b1;
            w_addr_d  = CORR_ACK;
         end
         ST_POLL_HI, ST_POLL_LO: if (w_ack_ok) begin
            if (r_state == ST_POLL_HI) begin
               w_state_d = ST_RD;
               w_cnt_d   = 3'd0;
               w_rd_d    = 1'b1;
               w_addr_d  = CORR_RES_BASE;
            end else begin
               w_state_d    = ST_NEXT;
               w_in_ready_d = !w_last;
            end
         end else if (r_poll == c_POLL_LAST) begin
            w_state_d = ST_ABORT;
            w_err_d   = 1'b1;
            w_wr_d    = 1'b1;
            w_addr_d  = CORR_SYNC;
            w_wdata_d = 32'd0;
         end else begin
            w_poll_d = r_poll + c_POLL_W'(1);
            w_rd_d   = 1'b1;
            w_addr_d = CORR_ACK;
         end
         ST_RD: begin
            w_state_d     = ST_OUT;
            w_res_data_d  = avm.avm_readdata;
            w_res_lag_d   = {1'b0, r_win, 2'b00} + (N_WIN_W+3)'(r_cnt);
            w_res_valid_d = 1'b1;
         end
         ST_OUT: if (res_ready) begin
            w_res_valid_d = 1'b0;
            if (r_cnt < 3'(CORR_LAGS - 1)) begin
               w_state_d = ST_RD;
               w_cnt_d   = r_cnt + 3'd1;
               w_rd_d    = 1'b1;
               w_addr_d  = corr_addr(CORR_RES_BASE, r_cnt + 3'd1);
            end else begin
               w_state_d = ST_SYNC_LO;
               w_wr_d    = 1'b1;
               w_addr_d  = CORR_SYNC;
               w_wdata_d = 32'd0;
            end
         end
         ST_NEXT: if (w_last) begin
            w_state_d = ST_DONE;
            w_done_d  = 1'b1;
         end else if (in_valid) begin
            // slot 1 becomes slot 0 at this edge, so it is the first word rewritten
            w_win_shift  = 1'b1;
            w_win_d      = r_win + 1'b1;
            w_in_ready_d = 1'b0;
            w_state_d    = ST_WR_SIG;
            w_cnt_d      = 3'd0;
            w_rd_idx     = 3'd1;
            w_wr_d       = 1'b1;
            w_addr_d     = CORR_SIG_BASE;
            w_wdata_d    = w_rd_word;
         end
         ST_ABORT: begin
            w_state_d = ST_DONE;
            w_done_d  = 1'b1;
         end
         ST_DONE:  w_state_d = ST_IDLE;
         default:  w_state_d = ST_IDLE;
      endcase

      w_busy_d = (w_state_d != ST_IDLE) && (w_state_d != ST_DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 3'd0;
         r_poll      <= '0;
         r_win       <= '0;
         r_nwin      <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_in_ready  <= 1'b0;
         r_res_data  <= '0;
         r_res_lag   <= '0;
         r_res_valid <= 1'b0;
         r_addr      <= '0;
         r_rd        <= 1'b0;
         r_wr        <= 1'b0;
         r_wdata     <= '0;
      end else begin
         r_state     <= w_state_d;
         r_cnt       <= w_cnt_d;
         r_poll      <= w_poll_d;
         r_win       <= w_win_d;
         r_nwin      <= w_nwin_d;
         r_busy      <= w_busy_d;
         r_done      <= w_done_d;
         r_err       <= w_err_d;
         r_in_ready  <= w_in_ready_d;
         r_res_data  <= w_res_data_d;
         r_res_lag   <= w_res_lag_d;
         r_res_valid <= w_res_valid_d;
         r_addr      <= w_addr_d;
         r_rd        <= w_rd_d;
         r_wr        <= w_wr_d;
         r_wdata     <= w_wdata_d;
      end
   end

   assign busy              = r_busy;
   assign done              = r_done;
   assign err               = r_err;
   assign in_ready          = r_in_ready;
   assign res_data          = r_res_data;
   assign res_lag           = r_res_lag;
   assign res_valid         = r_res_valid;
   assign avm.avm_address   = r_addr;
   assign avm.avm_read      = r_rd;
   assign avm.avm_write     = r_wr;
   assign avm.avm_writedata = r_wdata;
endmodule
`default_nettype wire

// File: tb/tb_corr_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_corr_sequencer
// Purpose : Randomised bench for corr_sequencer with a correlator slave model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_corr_sequencer;
   import corr_pkg::*;

   localparam int N_WIN_W = 16;
   localparam int ACK_TO  = 8;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               start = 1'b0;
   logic [N_WIN_W-1:0] num_windows = '0;
   logic               busy, done, err;
   logic [31:0]        in_data = '0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [31:0]        res_data;
   logic [N_WIN_W+2:0] res_lag;
   logic               res_valid;
   logic               res_ready = 1'b1;

   corr_sequencer_if bus ();

   corr_sequencer #(.N_WIN_W(N_WIN_W), .ACK_TIMEOUT(ACK_TO)) dut (
      .clk (clk), .reset_n (reset_n), .start (start), .num_windows (num_windows),
      .busy (busy), .done (done), .err (err),
      .in_data (in_data), .in_valid (in_valid), .in_ready (in_ready),
      .res_data (res_data), .res_lag (res_lag), .res_valid (res_valid), .res_ready (res_ready),
      .avm (bus.master)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_miss = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   function automatic int sbyte(input logic [31:0] w, input int i);
      logic [7:0] b;
      b = w[8*i +: 8];
      return int'($signed(b));
   endfunction

   // ---------------- correlator slave model ----------------
   logic [31:0] cregs [9];
   logic [31:0] cres  [5];
   logic        c_sync = 1'b0, c_ack = 1'b0, ack_stuck = 1'b0;
   logic [31:0] rdata;
   int n_sync1 = 0, n_sync0 = 0, n_ackrd = 0, n_rd_out = 0, n_rw_both = 0, n_inrdy = 0;

   function automatic int model_lag(input int k);
      int s = 0;
      for (int i = 0; i < 16; i++)
         s += sbyte(cregs[i/4], i%4) * sbyte(cregs[4 + (k+i)/4], (k+i)%4);
      return s;
   endfunction

   initial begin
      for (int i = 0; i < 9; i++) cregs[i] = '0;
      for (int i = 0; i < 5; i++) cres[i] = '0;
      forever begin
         @(posedge clk);
         c_ack <= c_sync;
         if (bus.avm_write) begin
            if (bus.avm_address < 8'd9) cregs[bus.avm_address] <= bus.avm_writedata;
            if (bus.avm_address == CORR_SYNC) begin
               c_sync <= bus.avm_writedata[0];
               if (bus.avm_writedata[0]) begin
                  n_sync1++;
                  for (int k = 0; k < 5; k++) cres[k] <= model_lag(k);
               end else n_sync0++;
            end
         end
         if (bus.avm_read && bus.avm_address == CORR_ACK) n_ackrd++;
         if (bus.avm_read && res_valid) n_rd_out++;
         if (bus.avm_read && bus.avm_write) n_rw_both++;
         if (in_ready) n_inrdy++;
      end
   end

   always_comb begin
      rdata = '0;
      if (bus.avm_address == CORR_ACK) rdata = {31'b0, c_ack & ~ack_stuck};
      else if (bus.avm_address >= CORR_RES_BASE && bus.avm_address < CORR_RES_BASE + 8'd5)
         rdata = cres[int'(bus.avm_address - CORR_RES_BASE)];
   end
   assign bus.avm_readdata = rdata;

   // ---------------- input source ----------------
   logic [31:0] in_q [$];
   bit gap_en = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         if (in_valid && in_ready && in_q.size() > 0) void'(in_q.pop_front());
         #1;
         if (in_q.size() > 0 && (!gap_en || $urandom_range(3) != 0)) begin
            in_valid = 1'b1;
            in_data  = in_q[0];
         end else in_valid = 1'b0;
      end
   end

   // ---------------- result sink / scoreboard ----------------
   int          exp_data [$];
   int          exp_lag  [$];
   bit          bp_en = 1'b0;
   int          hold_cnt = 0;
   logic [31:0] held_data;
   logic [N_WIN_W+2:0] held_lag;

   initial begin
      forever begin
         @(posedge clk);
         if (res_valid && res_ready) begin
            if (exp_data.size() == 0) check_val("res_unexpected", res_valid, 0);
            else begin
               check_val("res_data", res_data, exp_data.pop_front());
               check_val("res_lag", res_lag, exp_lag.pop_front());
            end
            if (hold_cnt > 0) begin
               check_val("res_hold_data", res_data, held_data);
               check_val("res_hold_lag", res_lag, held_lag);
            end
            hold_cnt = 0;
         end else if (res_valid) begin
            if (hold_cnt == 0) begin
               held_data = res_data;
               held_lag  = res_lag;
            end
            hold_cnt++;
         end else hold_cnt = 0;
         #1;
         res_ready = bp_en ? (res_valid && hold_cnt >= 10) : 1'b1;
      end
   end

   // ---------------- job helpers ----------------
   int s_sync1, s_sync0, s_ackrd, s_rd_out, s_inrdy;

   task automatic prep_job(input int nwin, input bit directed);
      logic [31:0] tw [4];
      logic [31:0] sw [$];
      for (int i = 0; i < 4; i++) tw[i] = directed ? 32'h01010101 : $urandom;
      for (int j = 0; j < nwin + 4; j++) begin
         logic [31:0] w;
         for (int b = 0; b < 4; b++) w[8*b +: 8] = directed ? 8'(4*j + b + 1) : 8'($urandom);
         sw.push_back(w);
      end
      for (int i = 0; i < 4; i++) in_q.push_back(tw[i]);
      foreach (sw[j]) in_q.push_back(sw[j]);
      // Absolute lag L correlates template byte i with stream byte L+i.
      for (int w = 0; w < nwin; w++)
         for (int k = 0; k < 5; k++) begin
            int lag = 4*w + k;
            int s = 0;
            for (int i = 0; i < 16; i++)
               s += sbyte(tw[i/4], i%4) * sbyte(sw[(lag+i)/4], (lag+i)%4);
            exp_data.push_back(directed ? 136 + 16*k : s);
            exp_lag.push_back(lag);
         end
      s_sync1 = n_sync1; s_sync0 = n_sync0; s_ackrd = n_ackrd;
      s_rd_out = n_rd_out; s_inrdy = n_inrdy;
   endtask

   task automatic launch(input int nwin);
      @(negedge clk);
      start = 1'b1;
      num_windows = N_WIN_W'(nwin);
      @(negedge clk);
      start = 1'b0;
      check_val("busy_after_start", busy, 1);
      check_val("err_cleared", err, 0);
      check_val("clr_write", bus.avm_write, 1);
      check_val("clr_addr", bus.avm_address, CORR_SYNC);
      check_val("clr_data", bus.avm_writedata, 0);
   endtask

   task automatic finish_job(input int nwin, input bit stuck);
      int n = 1;
      while (!done && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check_val("done_seen", done, 1);
      if (nwin == 0) check_val("done_latency", n, 2);
      check_val("err_at_done", err, stuck);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("start_on_done_ignored", busy, 0);
      check_val("done_one_cycle", done, 0);
      check_val("results_missing", exp_data.size(), 0);
      check_val("reads_during_out", n_rd_out - s_rd_out, 0);
      check_val("read_write_overlap", n_rw_both, 0);
      if (stuck) begin
         check_val("timeout_ack_reads", n_ackrd - s_ackrd, ACK_TO);
         check_val("timeout_sync0", n_sync0 - s_sync0, 2);
         check_val("timeout_left", in_q.size(), nwin + 8 - 9);
      end else begin
         check_val("sync1_writes", n_sync1 - s_sync1, nwin);
         check_val("sync0_writes", n_sync0 - s_sync0, nwin + 1);
         if (nwin == 0) begin
            check_val("zero_in_ready", n_inrdy - s_inrdy, 0);
            check_val("zero_unconsumed", in_q.size(), 8);
         end else check_val("input_consumed", in_q.size(), 0);
      end
      in_q.delete();
      exp_data.delete();
      exp_lag.delete();
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_done"}, done, 0);
      check_val({tag, "_err"}, err, 0);
      check_val({tag, "_in_ready"}, in_ready, 0);
      check_val({tag, "_res_valid"}, res_valid, 0);
      check_val({tag, "_res_data"}, res_data, 0);
      check_val({tag, "_res_lag"}, res_lag, 0);
      check_val({tag, "_read"}, bus.avm_read, 0);
      check_val({tag, "_write"}, bus.avm_write, 0);
      check_val({tag, "_addr"}, bus.avm_address, 0);
      check_val({tag, "_wdata"}, bus.avm_writedata, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      prep_job(1, 1'b1); launch(1); finish_job(1, 1'b0);

      gap_en = 1'b1;
      prep_job(3, 1'b0); launch(3); finish_job(3, 1'b0);

      bp_en = 1'b1;
      prep_job(2, 1'b0); launch(2); finish_job(2, 1'b0);
      bp_en = 1'b0;

      prep_job(0, 1'b0); launch(0); finish_job(0, 1'b0);

      ack_stuck = 1'b1;
      prep_job(2, 1'b0); exp_data.delete(); exp_lag.delete();
      launch(2); finish_job(2, 1'b1);
      ack_stuck = 1'b0;
      prep_job(1, 1'b0); launch(1); finish_job(1, 1'b0);

      // reset while the first window is polling for ack
      prep_job(2, 1'b0); launch(2);
      begin
         int n = 0;
         while (!(bus.avm_read && bus.avm_address == CORR_ACK) && n < 500) begin
            @(negedge clk);
            n++;
         end
         check_val("poll_hi_reached", bus.avm_read, 1);
      end
      reset_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      in_q.delete(); exp_data.delete(); exp_lag.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      prep_job(2, 1'b0); launch(2); finish_job(2, 1'b0);

      for (int r = 0; r < 4; r++) begin
         int nw = int'($urandom_range(4, 1));
         gap_en = 1'($urandom_range(1));
         bp_en  = 1'($urandom_range(1));
         prep_job(nw, 1'b0); launch(nw); finish_job(nw, 1'b0);
      end
      bp_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
`default_nettype wire
